// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer: PC/MAR ownership, 1/2-byte fetch, issue handshake, redirect
module fetch_unit #(
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DATA_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instr_opcode,
   output logic [DATA_WIDTH-1:0] instr_operand,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc
);

   typedef enum logic [2:0] {
      S_ADDR_OP  = 3'd0,
      S_READ_OP  = 3'd1,
      S_ADDR_ARG = 3'd2,
      S_READ_ARG = 3'd3,
      S_ISSUE    = 3'd4
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] mar_q, mar_d;
   logic [DATA_WIDTH-1:0] ir_q, ir_d;
   logic [DATA_WIDTH-1:0] operand_q, operand_d;
   logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      mar_d      = mar_q;
      ir_d       = ir_q;
      operand_d  = operand_q;
      instr_pc_d = instr_pc_q;

      case (state_q)
         S_ADDR_OP: begin
            mar_d      = pc_q;
            instr_pc_d = pc_q;
            state_d    = S_READ_OP;
         end
         S_READ_OP: begin
            ir_d = mem_rdata;
            pc_d = pc_q + 1'b1;
            if (mem_rdata[DATA_WIDTH-1]) begin
               state_d = S_ADDR_ARG;
            end else begin
               operand_d = '0;
               state_d   = S_ISSUE;
            end
         end
         S_ADDR_ARG: begin
            mar_d   = pc_q;
            state_d = S_READ_ARG;
         end
         S_READ_ARG: begin
            operand_d = mem_rdata;
            pc_d      = pc_q + 1'b1;
            state_d   = S_ISSUE;
         end
         S_ISSUE: begin
            if (instr_ready) begin
               state_d = S_ADDR_OP;
            end
         end
         default: state_d = S_ADDR_OP;
      endcase

      // Redirect wins over every state; a same-cycle handshake has already been taken by execute.
      if (redirect_valid) begin
         pc_d    = redirect_pc;
         state_d = S_ADDR_OP;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_ADDR_OP;
         pc_q       <= RESET_PC;
         mar_q      <= '0;
         ir_q       <= '0;
         operand_q  <= '0;
         instr_pc_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         mar_q      <= mar_d;
         ir_q       <= ir_d;
         operand_q  <= operand_d;
         instr_pc_q <= instr_pc_d;
      end
   end

   assign mem_addr      = mar_q;
   assign instr_valid   = (state_q == S_ISSUE);
   assign instr_opcode  = ir_q;
   assign instr_operand = operand_q;
   assign instr_pc      = instr_pc_q;

endmodule
